uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal values 5 to 8.
REQ-002 Parameter PARITY_EN, default 0; 1 inserts a parity bit after the data bits.
REQ-003 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-005 Port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1, reset: synchronous, active-low.
REQ-007 Port BCLK, input, 1, baud tick: a one-clk-wide pulse, once per bit period, from the baud generator.
REQ-008 Port tx_data, input, DATA_BITS, word to transmit, sampled on acceptance.
REQ-009 Port tx_start, input, 1, request to send tx_data.
REQ-010 Port tx_busy, output, 1, high while a frame is in progress.
REQ-011 Port tx_done, output, 1, one-clk pulse at frame completion.
REQ-012 Port TX, output, 1, registered serial line; idle level is 1.

Function
REQ-013 The FSM SHALL have the states IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-014 In IDLE, tx_start=1 SHALL latch tx_data into the shift register and move the FSM to SYNC on the next edge; tx_busy SHALL go high on the same edge.
REQ-015 A tick (BCLK=1) arriving in the cycle a request is accepted SHALL NOT be consumed; SYNC waits for the next tick.
REQ-016 The FSM SHALL advance only on cycles with BCLK=1, as follows:
- SYNC->START: TX=0.
- START->DATA: TX=bit0.
- DATA: shifts the word out LSB first, one bit per tick, for DATA_BITS ticks.
- After the last data bit: -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY: TX = XOR of the data bits, inverted if PARITY_ODD=1.
- STOP: TX=1 for STOP_BITS tick periods.
REQ-017 Each bit SHALL occupy exactly one tick period on TX; TX SHALL change only on the edge following a BCLK=1 cycle.
REQ-018 On the tick ending the last stop bit, the FSM SHALL enter IDLE, set tx_busy=0 and pulse tx_done=1 for exactly one clk.
REQ-019 tx_start SHALL be ignored while tx_busy=1; the latched word SHALL NOT change mid-frame.
REQ-020 tx_start=1 in the cycle tx_done=1 (FSM already in IDLE) SHALL be accepted, giving back-to-back frames with no extra idle bit beyond one SYNC wait.
REQ-021 TX SHALL be 1 in IDLE and in SYNC.
REQ-022 The bit counter SHALL be 3 bits wide, SHALL count 0..DATA_BITS-1, and SHALL reset to 0 on each DATA entry; it SHALL never wrap inside a frame.
REQ-023 The frame length in ticks after SYNC SHALL be 1 + DATA_BITS + PARITY_EN + STOP_BITS.

Reset
REQ-024 When rst=0 at a rising clk edge: state=IDLE, TX=1, tx_busy=0, tx_done=0, bit counter=0, shift register=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; TX=1 from the next edge and no tx_done pulse SHALL be produced.
REQ-026 No output SHALL be X after the first clk edge with rst=0.

Structure
REQ-027 The state encoding constants and the parity-mode constants (EVEN, ODD) SHALL live in the shared UART package, so the receiver and APB wrapper use the same values.
REQ-028 The block SHALL be a single module with no sub-modules; BCLK SHALL come from the existing baud generator instantiated by the parent.

Verification
REQ-029 8N1, BCLK every 16 clk, tx_data=0xA5 -> TX = 0,1,0,1,0,0,1,0,1,1, each held 16 clk; tx_done pulses once; tx_busy spans SYNC through the last stop bit.
REQ-030 8E1, tx_data=0x07 -> parity bit=1; 8O1, tx_data=0x07 -> parity bit=0; frame length 11 ticks after SYNC.
REQ-031 tx_start re-asserted with 0xFF mid-frame of 0x3C -> the 0x3C frame is unchanged; no second frame follows.
REQ-032 rst=0 for one clk during data bit 3 -> TX=1 next edge, tx_busy=0, no tx_done; a new tx_start afterwards sends a clean frame.
REQ-033 tx_start held in the tx_done cycle, STOP_BITS=2 -> second frame accepted immediately; the gap between frames is two stop ticks plus one SYNC wait.
REQ-034 tx_start and BCLK coincident in IDLE -> the start bit begins at the following tick, not that one.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared UART definitions used by the transmitter, the receiver and the APB
// wrapper, so every block agrees on state and parity-mode encodings.
//   tx_state_t    : transmitter FSM states
//   EVEN / ODD    : parity-mode constants
//   MAX_DATA_BITS : widest supported data word
//   parity_bit()  : parity of a word (zero-extended to MAX_DATA_BITS)
// ---------------------------------------------------------------------------
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int unsigned MAX_DATA_BITS = 8;

  // Zero-extension of narrower words does not change the XOR, so one
  // fixed-width helper serves every DATA_BITS setting.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] word,
                                      input logic                     mode);
    return (^word) ^ (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter. A request in IDLE latches the word, then the frame
// (start, DATA_BITS data LSB first, optional parity, STOP_BITS stops) is
// clocked out one bit per BCLK tick.
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active low
//   BCLK     : one-clk baud tick from the parent's baud generator
//   tx_data  : word to send, captured when a request is accepted
//   tx_start : send request, only honoured in IDLE
//   tx_busy  : high from acceptance until the last stop bit ends
//   tx_done  : one-clk pulse when the frame completes
//   TX       : registered serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 BCLK,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 TX
);

  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic       HAS_PARITY = (PARITY_EN != 0);
  localparam logic       PAR_MODE   = (PARITY_ODD != 0) ? ODD : EVEN;

  tx_state_t              state,   state_n;
  logic [DATA_BITS-1:0]   shreg,   shreg_n;
  logic [2:0]             bitcnt,  bitcnt_n;
  logic                   stopcnt, stopcnt_n;
  logic                   par,     par_n;
  logic                   tx_n;
  logic                   busy_n;
  logic                   done_n;
  logic [MAX_DATA_BITS-1:0] word_ext;

  always_comb begin
    word_ext                  = '0;
    word_ext[DATA_BITS-1:0]   = tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      par     <= 1'b0;
      TX      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bitcnt  <= bitcnt_n;
      stopcnt <= stopcnt_n;
      par     <= par_n;
      TX      <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end

  // TX holds the bit for the state being entered, so each state's name
  // describes what is currently on the line. Parity is computed once at
  // acceptance because the shift register is consumed as bits go out.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bitcnt_n  = bitcnt;
    stopcnt_n = stopcnt;
    par_n     = par;
    tx_n      = TX;
    busy_n    = tx_busy;
    done_n    = 1'b0;

    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        // BCLK is deliberately ignored here; SYNC waits for a fresh tick.
        if (tx_start) begin
          state_n = SYNC;
          shreg_n = tx_data;
          par_n   = parity_bit(word_ext, PAR_MODE);
          busy_n  = 1'b1;
        end
      end

      SYNC: begin
        if (BCLK) begin
          state_n = START;
          tx_n    = 1'b0;
        end
      end

      START: begin
        if (BCLK) begin
          state_n  = DATA;
          tx_n     = shreg[0];
          shreg_n  = shreg >> 1;
          bitcnt_n = '0;
        end
      end

      DATA: begin
        if (BCLK) begin
          if (bitcnt == LAST_BIT) begin
            if (HAS_PARITY) begin
              state_n = PARITY;
              tx_n    = par;
            end else begin
              state_n   = STOP;
              tx_n      = 1'b1;
              stopcnt_n = 1'b0;
            end
          end else begin
            tx_n     = shreg[0];
            shreg_n  = shreg >> 1;
            bitcnt_n = bitcnt + 3'd1;
          end
        end
      end

      PARITY: begin
        if (BCLK) begin
          state_n   = STOP;
          tx_n      = 1'b1;
          stopcnt_n = 1'b0;
        end
      end

      STOP: begin
        if (BCLK) begin
          if (stopcnt == LAST_STOP) begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            stopcnt_n = stopcnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Four transmitter instances (8N1, 8E1, 8O1, 5O2) share clk, rst, BCLK and a
// data bus; each has its own start line. Every scenario records per-cycle
// stimulus and DUT outputs, then a line-level reference model (frame bit
// list plus tick counting) produces the expected TX/busy/done per cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       BCLK = 1'b0;
  logic [3:0] start;
  logic [7:0] data;
  logic [3:0] busy, done, tx;

  int total = 0;
  int bad   = 0;

  uart_tx u0 (.clk(clk), .rst(rst), .BCLK(BCLK), .tx_data(data),
              .tx_start(start[0]), .tx_busy(busy[0]), .tx_done(done[0]), .TX(tx[0]));
  uart_tx #(.PARITY_EN(1)) u1 (.clk(clk), .rst(rst), .BCLK(BCLK), .tx_data(data),
              .tx_start(start[1]), .tx_busy(busy[1]), .tx_done(done[1]), .TX(tx[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .BCLK(BCLK), .tx_data(data),
              .tx_start(start[2]), .tx_busy(busy[2]), .tx_done(done[2]), .TX(tx[2]));
  uart_tx #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u3 (
              .clk(clk), .rst(rst), .BCLK(BCLK), .tx_data(data[4:0]),
              .tx_start(start[3]), .tx_busy(busy[3]), .tx_done(done[3]), .TX(tx[3]));

  always #5 clk = ~clk;

  // Baud tick: one-clk pulse every div clocks.
  int div     = 16;
  bit tick_en = 1'b0;
  int bcnt    = 0;
  always @(negedge clk) begin
    if (!tick_en) begin
      bcnt <= 0;
      BCLK <= 1'b0;
    end else if (bcnt >= div - 1) begin
      bcnt <= 0;
      BCLK <= 1'b1;
    end else begin
      bcnt <= bcnt + 1;
      BCLK <= 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Per-instance configuration.
  function automatic int db_of(input int k); return (k == 3) ? 5 : 8; endfunction
  function automatic int pe_of(input int k); return (k == 0) ? 0 : 1; endfunction
  function automatic int po_of(input int k); return (k >= 2) ? 1 : 0; endfunction
  function automatic int sb_of(input int k); return (k == 3) ? 2 : 1; endfunction
  function automatic int frame_len(input int k);
    return 1 + db_of(k) + pe_of(k) + sb_of(k);
  endfunction

  // Line bits of one frame, in transmission order, index 0 = start bit.
  function automatic logic [15:0] frame_vec(input int k, input logic [7:0] d);
    logic [15:0] v;
    logic p;
    v = '1;
    v[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < db_of(k); i++) begin
      v[1+i] = d[i];
      p = p ^ d[i];
    end
    if (pe_of(k) != 0) v[1+db_of(k)] = p ^ (po_of(k) != 0);
    return v;
  endfunction

  // Capture of one scenario.
  logic       req_q[$], rst_q[$], tick_q[$];
  logic [7:0] dat_q[$];
  logic       tx_q[$], busy_q[$], done_q[$];
  logic       exp_tx[$], exp_busy[$], exp_done[$];

  task automatic clear_cap();
    req_q.delete(); rst_q.delete(); tick_q.delete(); dat_q.delete();
    tx_q.delete(); busy_q.delete(); done_q.delete();
  endtask

  // Called at negedge+1 with inputs already set for the coming rising edge.
  task automatic step(input int k);
    req_q.push_back(start[k]);
    dat_q.push_back(data);
    rst_q.push_back(rst);
    tick_q.push_back(BCLK);
    @(posedge clk);
    @(negedge clk);
    #1;
    tx_q.push_back(tx[k]);
    busy_q.push_back(busy[k]);
    done_q.push_back(done[k]);
  endtask

  // Reference: a frame is either in flight (j = ticks since acceptance) or
  // not. Requests only start a frame when none is in flight; the tick of the
  // accepting edge does not count; tick n+1 ends the frame with a done pulse.
  task automatic run_model(input int k);
    bit          active;
    int          j, n;
    logic [15:0] fv;
    logic        ed;
    active = 1'b0; j = 0; n = frame_len(k); fv = '1;
    exp_tx.delete(); exp_busy.delete(); exp_done.delete();
    for (int i = 0; i < req_q.size(); i++) begin
      ed = 1'b0;
      if (rst_q[i] !== 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (req_q[i] === 1'b1) begin
          active = 1'b1;
          j = 0;
          fv = frame_vec(k, dat_q[i]);
        end
      end else if (tick_q[i] === 1'b1) begin
        j++;
        if (j == n + 1) begin
          active = 1'b0;
          ed = 1'b1;
        end
      end
      exp_busy.push_back(active);
      exp_done.push_back(ed);
      exp_tx.push_back((active && j > 0) ? fv[j-1] : 1'b1);
    end
  endtask

  task automatic count_diffs(output int dtx, output int dbz, output int ddn, output int first);
    dtx = 0; dbz = 0; ddn = 0; first = -1;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (tx_q[i] !== exp_tx[i]) begin dtx++; if (first < 0) first = i; end
      if (busy_q[i] !== exp_busy[i]) begin dbz++; if (first < 0) first = i; end
      if (done_q[i] !== exp_done[i]) begin ddn++; if (first < 0) first = i; end
    end
  endtask

  // TX values seen after each tick edge following cycle a.
  function automatic logic [31:0] tick_samples(input int a, input int cnt);
    logic [31:0] v;
    int m;
    v = '0; m = 0;
    for (int i = a + 1; i < tick_q.size() && m < cnt; i++)
      if (tick_q[i] === 1'b1) begin v[m] = tx_q[i]; m++; end
    return v;
  endfunction

  function automatic int first_low(input int from);
    for (int i = from; i < tx_q.size(); i++) if (tx_q[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int first_done(input int from);
    for (int i = from; i < done_q.size(); i++) if (done_q[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int done_count();
    int c;
    c = 0;
    foreach (done_q[i]) if (done_q[i] === 1'b1) c++;
    return c;
  endfunction

  int dtx, dbz, ddn, fc;

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; start = '0; data = '0; tick_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int k = 0; k < NDUT; k++) begin
      total++; if (tx[k] !== 1'b1)   begin bad++; $display("FAIL reset_tx[%0d] got %b exp 1", k, tx[k]); end
      total++; if (busy[k] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got %b exp 0", k, busy[k]); end
      total++; if (done[k] !== 1'b0) begin bad++; $display("FAIL reset_done[%0d] got %b exp 0", k, done[k]); end
    end
    rst = 1'b1; tick_en = 1'b1;
    @(negedge clk); #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_8n1_a5();
    int a, fall, dn;
    logic [31:0] s;
    logic [9:0]  s10;
    div = 16; clear_cap();
    repeat ($urandom_range(0, 15)) step(0);
    a = req_q.size();
    data = 8'hA5; start[0] = 1'b1; step(0); start[0] = 1'b0;
    repeat (13 * 16) step(0);
    run_model(0); count_diffs(dtx, dbz, ddn, fc);
    total++; if (dtx != 0) begin bad++; $display("FAIL a5_tx_wave diffs=%0d first=%0d exp 0", dtx, fc); end
    total++; if (dbz != 0) begin bad++; $display("FAIL a5_busy_wave diffs=%0d first=%0d exp 0", dbz, fc); end
    total++; if (ddn != 0) begin bad++; $display("FAIL a5_done_wave diffs=%0d first=%0d exp 0", ddn, fc); end
    s = tick_samples(a, 10); s10 = s[9:0];
    total++; if (s10 !== 10'b1101001010) begin bad++; $display("FAIL a5_bits got %b exp 1101001010", s10); end
    total++; if (done_count() != 1) begin bad++; $display("FAIL a5_done_count got %0d exp 1", done_count()); end
    fall = first_low(a); dn = first_done(a);
    total++; if (dn - fall != 160) begin bad++; $display("FAIL a5_frame_clks got %0d exp 160", dn - fall); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_parity();
    int a, fall, dn;
    logic [31:0] s;
    logic exp_par;
    for (int k = 1; k <= 2; k++) begin
      div = 10; clear_cap();
      repeat ($urandom_range(0, 9)) step(k);
      a = req_q.size();
      data = 8'h07; start[k] = 1'b1; step(k); start[k] = 1'b0;
      repeat (14 * 10) step(k);
      run_model(k); count_diffs(dtx, dbz, ddn, fc);
      total++; if (dtx + dbz + ddn != 0) begin bad++; $display("FAIL parity%0d_wave diffs=%0d/%0d/%0d first=%0d exp 0", k, dtx, dbz, ddn, fc); end
      s = tick_samples(a, 11);
      exp_par = (k == 1) ? 1'b1 : 1'b0;
      total++; if (s[9] !== exp_par) begin bad++; $display("FAIL parity%0d_bit got %b exp %b", k, s[9], exp_par); end
      fall = first_low(a); dn = first_done(a);
      total++; if (dn - fall != 11 * 10) begin bad++; $display("FAIL parity%0d_len_clks got %0d exp 110", k, dn - fall); end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_coincident();
    int a, g, fall;
    div = 10; clear_cap(); g = 0;
    while (BCLK !== 1'b1 && g < 40) begin step(0); g++; end
    a = req_q.size();
    data = 8'h5A; start[0] = 1'b1; step(0); start[0] = 1'b0;
    repeat (12 * 10) step(0);
    run_model(0); count_diffs(dtx, dbz, ddn, fc);
    total++; if (dtx + dbz + ddn != 0) begin bad++; $display("FAIL coincident_wave diffs=%0d/%0d/%0d first=%0d exp 0", dtx, dbz, ddn, fc); end
    fall = first_low(a);
    total++; if (fall - a != 10) begin bad++; $display("FAIL coincident_start_delay got %0d exp 10", fall - a); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_ignore_start();
    int a;
    logic [31:0] s;
    logic [9:0]  s10;
    div = 12; clear_cap();
    a = req_q.size();
    data = 8'h3C; start[0] = 1'b1; step(0); start[0] = 1'b0;
    repeat (5 * 12) step(0);
    data = 8'hFF; start[0] = 1'b1; step(0); step(0); start[0] = 1'b0;
    repeat (9 * 12) step(0);
    run_model(0); count_diffs(dtx, dbz, ddn, fc);
    total++; if (dtx + dbz + ddn != 0) begin bad++; $display("FAIL ignore_wave diffs=%0d/%0d/%0d first=%0d exp 0", dtx, dbz, ddn, fc); end
    s = tick_samples(a, 10); s10 = s[9:0];
    total++; if (s10 !== 10'b1001111000) begin bad++; $display("FAIL ignore_bits got %b exp 1001111000", s10); end
    total++; if (done_count() != 1) begin bad++; $display("FAIL ignore_done_count got %0d exp 1", done_count()); end
    total++; if (busy_q[busy_q.size()-1] !== 1'b0) begin bad++; $display("FAIL ignore_tail_busy got %b exp 0", busy_q[busy_q.size()-1]); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_midframe();
    int a, nt, g, idx;
    div = 8; clear_cap();
    a = req_q.size();
    data = 8'($urandom); start[0] = 1'b1; step(0); start[0] = 1'b0;
    nt = 0; g = 0;
    while (nt < 5 && g < 300) begin
      step(0);
      if (tick_q[tick_q.size()-1] === 1'b1) nt++;
      g++;
    end
    total++; if (nt != 5) begin bad++; $display("FAIL rstmid_reach_bit3 ticks=%0d exp 5", nt); end
    step(0); step(0);
    rst = 1'b0; step(0); rst = 1'b1;
    idx = tx_q.size() - 1;
    total++; if (tx_q[idx] !== 1'b1)   begin bad++; $display("FAIL rstmid_tx got %b exp 1", tx_q[idx]); end
    total++; if (busy_q[idx] !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b exp 0", busy_q[idx]); end
    repeat (4 * 8) step(0);
    total++; if (done_count() != 0) begin bad++; $display("FAIL rstmid_no_done got %0d exp 0", done_count()); end
    data = 8'($urandom); start[0] = 1'b1; step(0); start[0] = 1'b0;
    repeat (13 * 8) step(0);
    run_model(0); count_diffs(dtx, dbz, ddn, fc);
    total++; if (dtx + dbz + ddn != 0) begin bad++; $display("FAIL rstmid_wave diffs=%0d/%0d/%0d first=%0d exp 0", dtx, dbz, ddn, fc); end
    total++; if (done_count() != 1) begin bad++; $display("FAIL rstmid_clean_done got %0d exp 1", done_count()); end
    if (a < 0) $display("unreachable");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    int a, g, dn, fall2, n;
    logic [7:0]  d1, d2;
    logic [15:0] f1, f2;
    logic [31:0] s, e;
    div = 6; clear_cap(); n = frame_len(3);
    d1 = 8'($urandom); d2 = 8'($urandom);
    a = req_q.size();
    data = d1; start[3] = 1'b1; step(3); start[3] = 1'b0;
    g = 0;
    while (done_q[done_q.size()-1] !== 1'b1 && g < 400) begin step(3); g++; end
    total++; if (g >= 400) begin bad++; $display("FAIL b2b_first_done timeout after %0d cycles", g); end
    dn = done_q.size() - 1;
    data = d2; start[3] = 1'b1; step(3); start[3] = 1'b0;
    total++; if (busy_q[dn+1] !== 1'b1) begin bad++; $display("FAIL b2b_accept busy got %b exp 1", busy_q[dn+1]); end
    repeat ((n + 3) * 6) step(3);
    run_model(3); count_diffs(dtx, dbz, ddn, fc);
    total++; if (dtx + dbz + ddn != 0) begin bad++; $display("FAIL b2b_wave diffs=%0d/%0d/%0d first=%0d exp 0", dtx, dbz, ddn, fc); end
    total++; if (done_count() != 2) begin bad++; $display("FAIL b2b_done_count got %0d exp 2", done_count()); end
    f1 = frame_vec(3, d1); f2 = frame_vec(3, d2);
    e = '0;
    for (int i = 0; i < n; i++) begin e[i] = f1[i]; e[n+1+i] = f2[i]; end
    e[n] = 1'b1;
    s = tick_samples(a, 2 * n + 1);
    total++; if (s !== e) begin bad++; $display("FAIL b2b_tick_bits got %h exp %h", s, e); end
    fall2 = first_low(dn + 1);
    total++; if (fall2 - dn != 6) begin bad++; $display("FAIL b2b_gap_clks got %0d exp 6", fall2 - dn); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random();
    int k, n, len, poke;
    for (int it = 0; it < 12; it++) begin
      k = int'($urandom_range(0, 3));
      div = int'($urandom_range(1, 20));
      n = frame_len(k);
      clear_cap();
      repeat ($urandom_range(0, 8)) step(k);
      data = 8'($urandom); start[k] = 1'b1; step(k); start[k] = 1'b0;
      len = (n + 3) * div + 4;
      poke = div + int'($urandom_range(1, (n - 1) * div));
      for (int c = 1; c <= len; c++) begin
        if (c == poke) begin start[k] = 1'b1; data = 8'($urandom); end
        else start[k] = 1'b0;
        step(k);
      end
      start[k] = 1'b0;
      run_model(k); count_diffs(dtx, dbz, ddn, fc);
      total++; if (dtx != 0) begin bad++; $display("FAIL rand%0d_k%0d_tx diffs=%0d first=%0d div=%0d exp 0", it, k, dtx, fc, div); end
      total++; if (dbz != 0) begin bad++; $display("FAIL rand%0d_k%0d_busy diffs=%0d first=%0d div=%0d exp 0", it, k, dbz, fc, div); end
      total++; if (ddn != 0) begin bad++; $display("FAIL rand%0d_k%0d_done diffs=%0d first=%0d div=%0d exp 0", it, k, ddn, fc, div); end
      total++; if (done_count() != 1) begin bad++; $display("FAIL rand%0d_k%0d_done_count got %0d exp 1", it, k, done_count()); end
    end
  endtask

  initial begin
    rst = 1'b0; start = '0; data = '0;
    test_reset();
    test_8n1_a5();
    test_parity();
    test_coincident();
    test_ignore_start();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
